// File: rtl/l2_cache_ctrl_nway_if.sv
// Controller <-> CPU / datapath / memory signal bundle for the N-way L2 cache controller.
// The master side is the controller; the slave side is the datapath and memory.
interface l2_cache_ctrl_nway_if #(
    parameter int WAYS  = 4,
    parameter int CNT_W = 32
);
    localparam int IDX_W = $clog2(WAYS);

    logic             mem_read;
    logic             mem_write;
    logic             hit;
    logic [IDX_W-1:0] hit_way;
    logic [WAYS-1:0]  valid_out;
    logic [WAYS-1:0]  dirty_out;
    logic [IDX_W-1:0] plru_victim;
    logic             pmem_resp;

    logic             pmem_read;
    logic             pmem_write;
    logic             wb_addr_sel;
    logic [WAYS-1:0]  ld_tag;
    logic [WAYS-1:0]  ld_valid;
    logic [WAYS-1:0]  ld_dirty;
    logic [WAYS-1:0]  ld_data;
    logic             valid_in;
    logic             dirty_in;
    logic             data_sel;
    logic             lru_ld;
    logic [IDX_W-1:0] lru_way;
    logic             mem_resp;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] wb_cnt;

    modport master (
        input  mem_read, mem_write, hit, hit_way, valid_out, dirty_out, plru_victim, pmem_resp,
        output pmem_read, pmem_write, wb_addr_sel, ld_tag, ld_valid, ld_dirty, ld_data,
               valid_in, dirty_in, data_sel, lru_ld, lru_way, mem_resp,
               hit_cnt, miss_cnt, wb_cnt
    );

    modport slave (
        output mem_read, mem_write, hit, hit_way, valid_out, dirty_out, plru_victim, pmem_resp,
        input  pmem_read, pmem_write, wb_addr_sel, ld_tag, ld_valid, ld_dirty, ld_data,
               valid_in, dirty_in, data_sel, lru_ld, lru_way, mem_resp,
               hit_cnt, miss_cnt, wb_cnt
    );
endinterface

// File: rtl/l2_cache_ctrl_nway.sv
// N-way write-back L2 cache controller: hit/miss sequencing, victim selection,
// writeback and fill control, with saturating hit/miss/writeback counters.
module l2_cache_ctrl_nway #(
    parameter int WAYS  = 4,
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    l2_cache_ctrl_nway_if.master bus
);
    localparam int IDX_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, CHECK, VICTIM, WRITEBACK, FILL} state_t;

    state_t           state;
    logic [IDX_W-1:0] victim;
    logic [IDX_W-1:0] victim_pick;
    logic [WAYS-1:0]  hit_oh;
    logic [WAYS-1:0]  victim_oh;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Prefer an invalid way (lowest index wins); fall back to the PLRU choice.
    always_comb begin
        victim_pick = bus.plru_victim;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_out[i]) victim_pick = IDX_W'(i);
        end
    end

    assign hit_oh    = WAYS'(1) << bus.hit_way;
    assign victim_oh = WAYS'(1) << victim;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            victim       <= '0;
            bus.hit_cnt  <= '0;
            bus.miss_cnt <= '0;
            bus.wb_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.mem_read || bus.mem_write) state <= CHECK;
                CHECK: begin
                    if (bus.hit) begin
                        state       <= IDLE;
                        bus.hit_cnt <= sat_inc(bus.hit_cnt);
                    end else begin
                        state        <= VICTIM;
                        bus.miss_cnt <= sat_inc(bus.miss_cnt);
                    end
                end
                VICTIM: begin
                    victim <= victim_pick;
                    if (bus.valid_out[victim_pick] && bus.dirty_out[victim_pick])
                        state <= WRITEBACK;
                    else
                        state <= FILL;
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state      <= FILL;
                        bus.wb_cnt <= sat_inc(bus.wb_cnt);
                    end
                end
                FILL: if (bus.pmem_resp) state <= CHECK;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes depend on the current state and the same-cycle datapath/memory inputs.
    always_comb begin
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.wb_addr_sel = 1'b0;
        bus.ld_tag      = '0;
        bus.ld_valid    = '0;
        bus.ld_dirty    = '0;
        bus.ld_data     = '0;
        bus.valid_in    = 1'b0;
        bus.dirty_in    = 1'b0;
        bus.data_sel    = 1'b0;
        bus.lru_ld      = 1'b0;
        bus.lru_way     = '0;
        bus.mem_resp    = 1'b0;
        case (state)
            CHECK: begin
                if (bus.hit) begin
                    bus.mem_resp = 1'b1;
                    bus.lru_ld   = 1'b1;
                    bus.lru_way  = bus.hit_way;
                    if (bus.mem_write) begin
                        bus.ld_data  = hit_oh;
                        bus.ld_dirty = hit_oh;
                        bus.dirty_in = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write  = 1'b1;
                bus.wb_addr_sel = 1'b1;
                if (bus.pmem_resp) bus.ld_dirty = victim_oh;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.ld_tag   = victim_oh;
                    bus.ld_valid = victim_oh;
                    bus.ld_data  = victim_oh;
                    bus.ld_dirty = victim_oh;
                    bus.valid_in = 1'b1;
                    bus.data_sel = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Bench for l2_cache_ctrl_nway: a transaction-level model expands each request into its
// expected per-cycle output trace; directed cases plus randomized requests with resets.
module tb_l2_cache_ctrl_nway;
    localparam int WAYS  = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_cache_ctrl_nway_if #(.WAYS(WAYS), .CNT_W(CNT_W)) bus ();
    l2_cache_ctrl_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       rst, rd, wr, hit;
        logic [1:0] hway;
        logic [3:0] vo, dout;
        logic [1:0] plru;
        logic       presp;
    } in_t;

    typedef struct packed {
        logic       care;
        logic       prd, pwr, wbsel;
        logic [3:0] ldt, ldv, ldd, ldda;
        logic       vin, din, dsel, lld;
        logic [1:0] lway;
        logic       mresp;
        logic [3:0] hc, mc, wc;
    } exp_t;

    in_t  in_q[$];
    exp_t exp_q[$];
    int   m_hit, m_miss, m_wb;
    int   abort_left;
    bit   aborted;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t cur_exp;
    bit   cmp_en = 1'b0;

    function automatic logic [3:0] oh(input logic [1:0] w);
        logic [3:0] one = 4'b0001;
        return one << w;
    endfunction

    function automatic int sat(input int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    function automatic in_t rand_in(input logic rd, input logic wr);
        in_t i;
        i.rst   = 1'b0;
        i.rd    = rd;
        i.wr    = wr;
        i.hit   = 1'($urandom_range(0, 1));
        i.hway  = 2'($urandom_range(0, 3));
        i.vo    = 4'($urandom_range(0, 15));
        i.dout  = 4'($urandom_range(0, 15));
        i.plru  = 2'($urandom_range(0, 3));
        i.presp = 1'($urandom_range(0, 1));
        return i;
    endfunction

    function automatic exp_t zexp();
        exp_t e = '0;
        e.care = 1'b1;
        return e;
    endfunction

    function automatic exp_t hit_exp(input logic [1:0] w, input logic wr);
        exp_t e = zexp();
        e.mresp = 1'b1;
        e.lld   = 1'b1;
        e.lway  = w;
        if (wr) begin
            e.ldda = oh(w);
            e.ldd  = oh(w);
            e.din  = 1'b1;
        end
        return e;
    endfunction

    // Appends one cycle; counters visible in a cycle reflect events of earlier cycles.
    task automatic emit(input in_t i, input exp_t e, input bit ev_hit, input bit ev_miss, input bit ev_wb);
        if (aborted) return;
        if (abort_left == 0) begin
            i.rst  = 1'b1;
            e      = zexp();
            e.care = 1'b0;
            in_q.push_back(i);
            exp_q.push_back(e);
            m_hit = 0; m_miss = 0; m_wb = 0;
            aborted = 1'b1;
            return;
        end
        abort_left--;
        e.hc = 4'(m_hit);
        e.mc = 4'(m_miss);
        e.wc = 4'(m_wb);
        in_q.push_back(i);
        exp_q.push_back(e);
        if (ev_hit)  m_hit  = sat(m_hit);
        if (ev_miss) m_miss = sat(m_miss);
        if (ev_wb)   m_wb   = sat(m_wb);
    endtask

    task automatic gen_txn(input logic rd, input logic wr, input logic hit0, input logic [1:0] hway,
                           input logic [3:0] vo, input logic [3:0] dout, input logic [1:0] plru,
                           input int ww, input int fw);
        in_t i; exp_t e; logic [1:0] v;
        i = rand_in(rd, wr);
        emit(i, zexp(), 0, 0, 0);
        i = rand_in(rd, wr);
        i.hit = hit0;
        if (hit0) begin
            i.hway = hway;
            emit(i, hit_exp(hway, wr), 1, 0, 0);
            return;
        end
        emit(i, zexp(), 0, 1, 0);
        i = rand_in(rd, wr);
        i.vo = vo; i.dout = dout; i.plru = plru;
        emit(i, zexp(), 0, 0, 0);
        v = plru;
        for (int k = 3; k >= 0; k--) if (!vo[k]) v = 2'(k);
        if (vo[v] && dout[v]) begin
            for (int k = 0; k < ww; k++) begin
                i = rand_in(rd, wr); i.presp = 1'b0;
                e = zexp(); e.pwr = 1'b1; e.wbsel = 1'b1;
                emit(i, e, 0, 0, 0);
            end
            i = rand_in(rd, wr); i.presp = 1'b1;
            e = zexp(); e.pwr = 1'b1; e.wbsel = 1'b1; e.ldd = oh(v);
            emit(i, e, 0, 0, 1);
        end
        for (int k = 0; k < fw; k++) begin
            i = rand_in(rd, wr); i.presp = 1'b0;
            e = zexp(); e.prd = 1'b1;
            emit(i, e, 0, 0, 0);
        end
        i = rand_in(rd, wr); i.presp = 1'b1;
        e = zexp(); e.prd = 1'b1; e.ldt = oh(v); e.ldv = oh(v); e.ldda = oh(v); e.ldd = oh(v);
        e.vin = 1'b1; e.dsel = 1'b1;
        emit(i, e, 0, 0, 0);
        i = rand_in(rd, wr); i.hit = 1'b1; i.hway = v;
        emit(i, hit_exp(v, wr), 1, 0, 0);
    endtask

    // A request interrupted by reset is held and replayed from IDLE when retry is set.
    task automatic txn(input logic rd, input logic wr, input logic hit0, input logic [1:0] hway,
                       input logic [3:0] vo, input logic [3:0] dout, input logic [1:0] plru,
                       input int ww, input int fw, input int abort_at, input bit retry);
        abort_left = abort_at;
        aborted    = 1'b0;
        gen_txn(rd, wr, hit0, hway, vo, dout, plru, ww, fw);
        if (aborted && retry) begin
            abort_left = NEVER;
            aborted    = 1'b0;
            gen_txn(rd, wr, hit0, hway, vo, dout, plru, ww, fw);
        end
        abort_left = NEVER;
        aborted    = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) emit(rand_in(1'b0, 1'b0), zexp(), 0, 0, 0);
    endtask

    task automatic drive(input in_t i);
        rst             = i.rst;
        bus.mem_read    = i.rd;
        bus.mem_write   = i.wr;
        bus.hit         = i.hit;
        bus.hit_way     = i.hway;
        bus.valid_out   = i.vo;
        bus.dirty_out   = i.dout;
        bus.plru_victim = i.plru;
        bus.pmem_resp   = i.presp;
    endtask

    task automatic run_q();
        while (in_q.size() > 0) begin
            @(posedge clk);
            #1;
            drive(in_q.pop_front());
            cur_exp = exp_q.pop_front();
            cmp_en  = 1'b1;
        end
        @(negedge clk);
        #1 cmp_en = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && cur_exp.care) begin
            logic [37:0] act, req;
            act = {bus.pmem_read, bus.pmem_write, bus.wb_addr_sel, bus.ld_tag, bus.ld_valid,
                   bus.ld_dirty, bus.ld_data, bus.valid_in, bus.dirty_in, bus.data_sel,
                   bus.lru_ld, bus.lru_way, bus.mem_resp, bus.hit_cnt, bus.miss_cnt, bus.wb_cnt};
            req = {cur_exp.prd, cur_exp.pwr, cur_exp.wbsel, cur_exp.ldt, cur_exp.ldv,
                   cur_exp.ldd, cur_exp.ldda, cur_exp.vin, cur_exp.din, cur_exp.dsel,
                   cur_exp.lld, cur_exp.lway, cur_exp.mresp, cur_exp.hc, cur_exp.mc, cur_exp.wc};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act, req);
            end
        end
    end

    initial begin
        logic rd, wr;
        int   r, ab;
        m_hit = 0; m_miss = 0; m_wb = 0;
        abort_left = NEVER;
        aborted    = 1'b0;
        drive(rand_in(1'b0, 1'b0));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 drive(rand_in(1'b0, 1'b0));
        @(negedge clk);
        lit("reset_mem_resp", 32'(bus.mem_resp), 0);
        lit("reset_pmem_read", 32'(bus.pmem_read), 0);
        lit("reset_pmem_write", 32'(bus.pmem_write), 0);
        lit("reset_hit_cnt", 32'(bus.hit_cnt), 0);
        lit("reset_miss_cnt", 32'(bus.miss_cnt), 0);

        // Read hit on way 2, then write hit on way 1.
        txn(1, 0, 1, 2'd2, 4'h0, 4'h0, 2'd0, 0, 0, NEVER, 1); gap(1); run_q();
        lit("read_hit_hit_cnt", 32'(bus.hit_cnt), 1);
        txn(0, 1, 1, 2'd1, 4'h0, 4'h0, 2'd0, 0, 0, NEVER, 1); gap(1); run_q();
        lit("write_hit_hit_cnt", 32'(bus.hit_cnt), 2);

        // Clean read miss into invalid way 2, then dirty write miss evicting way 0.
        txn(1, 0, 0, 2'd0, 4'b1011, 4'b0000, 2'd3, 0, 2, NEVER, 1); gap(1); run_q();
        lit("read_miss_miss_cnt", 32'(bus.miss_cnt), 1);
        lit("read_miss_wb_cnt", 32'(bus.wb_cnt), 0);
        lit("read_miss_hit_cnt", 32'(bus.hit_cnt), 3);
        txn(0, 1, 0, 2'd0, 4'b1111, 4'b0001, 2'd0, 2, 1, NEVER, 1); gap(1); run_q();
        lit("write_miss_wb_cnt", 32'(bus.wb_cnt), 1);
        lit("write_miss_miss_cnt", 32'(bus.miss_cnt), 2);
        lit("write_miss_hit_cnt", 32'(bus.hit_cnt), 4);

        // Reset pulsed in the middle of a fill wait.
        txn(1, 0, 0, 2'd0, 4'b1111, 4'b0000, 2'd3, 0, 3, 4, 0); gap(1); run_q();
        lit("fill_reset_pmem_read", 32'(bus.pmem_read), 0);
        lit("fill_reset_hit_cnt", 32'(bus.hit_cnt), 0);
        lit("fill_reset_miss_cnt", 32'(bus.miss_cnt), 0);

        // Sixteen back-to-back hits saturate the 4-bit hit counter.
        for (int k = 0; k < 16; k++) txn(1, 0, 1, 2'(k), 4'h0, 4'h0, 2'd0, 0, 0, NEVER, 1);
        gap(1); run_q();
        lit("hit_cnt_saturated", 32'(bus.hit_cnt), 15);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 2);
            rd = (r != 1);
            wr = (r != 0);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : NEVER;
            txn(rd, wr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), ab, 1);
            gap($urandom_range(0, 2));
            run_q();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
